// File: rtl/vga_scan_ctrl_if.sv
// Scan-controller bus: run/switch requests in, raster timing and colour select out.
// master = scan controller, slave = pixel colour generator / stimulus side.
interface vga_scan_ctrl_if;
  logic       run;
  logic [2:0] switches;
  logic       pix_tick;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       bright;
  logic       line_start;
  logic       frame_start;
  logic [2:0] color_sel;

  modport master (
    input  run, switches,
    output pix_tick, hcount, vcount, hsync, vsync, bright,
           line_start, frame_start, color_sel
  );

  modport slave (
    output run, switches,
    input  pix_tick, hcount, vcount, hsync, vsync, bright,
           line_start, frame_start, color_sel
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA raster sequencer: pixel-tick divider, h/v counters, sync/bright decode and
// frame-aligned colour latch. Define VGA_SCAN_SWITCH_SYNC_EN to add a 2-flop switch synchronizer.
module vga_scan_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515
) (
  input  logic             clk,
  input  logic             clr_n,
  vga_scan_ctrl_if.master  bus
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]      H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0]      V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0]      H_ACT_S  = 10'(H_ACT_START);
  localparam logic [9:0]      H_ACT_E  = 10'(H_ACT_END);
  localparam logic [9:0]      V_ACT_S  = 10'(V_ACT_START);
  localparam logic [9:0]      V_ACT_E  = 10'(V_ACT_END);

  logic [DIV_W-1:0] div;
  logic [9:0]       hcount, vcount;
  logic [9:0]       h_nxt, v_nxt;
  logic             hsync_q, vsync_q, bright_q;
  logic             pix_tick_q, line_start_q, frame_start_q;
  logic [2:0]       color_sel_q;
  logic [2:0]       sw_sample;
  logic             tick, h_wrap, v_wrap, frame_wrap;
  logic             hsync_nxt, vsync_nxt, bright_nxt;

`ifdef VGA_SCAN_SWITCH_SYNC_EN
  logic [2:0] sw_meta, sw_sync;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= bus.switches;
      sw_sync <= sw_meta;
    end
  end

  assign sw_sample = sw_sync;
`else
  assign sw_sample = bus.switches;
`endif

  assign tick       = bus.run && (div == DIV_LAST);
  assign h_wrap     = (hcount == H_LAST);
  assign v_wrap     = (vcount == V_LAST);
  assign frame_wrap = tick && h_wrap && v_wrap;

  // Sync and bright decode the counts that will be registered this edge, so they never lag the counters.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    h_nxt = hcount;
    v_nxt = vcount;
    if (tick) begin
      h_nxt = h_wrap ? '0 : hcount + 10'd1;
      if (h_wrap) v_nxt = v_wrap ? '0 : vcount + 10'd1;
    end
  end

  assign hsync_nxt  = (h_nxt >= H_SYNC_C);
  assign vsync_nxt  = (v_nxt >= V_SYNC_C);
  assign bright_nxt = (h_nxt >= H_ACT_S) && (h_nxt < H_ACT_E) &&
                      (v_nxt >= V_ACT_S) && (v_nxt < V_ACT_E);

  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!clr_n) begin
      div           <= '0;
      hcount        <= '0;
      vcount        <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      bright_q      <= 1'b0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      color_sel_q   <= 3'b000;
    end else if (!bus.run) begin
      // Idle parks at (0,0); color_sel is deliberately kept across the pause.
      div           <= '0;
      hcount        <= '0;
      vcount        <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      bright_q      <= 1'b0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div           <= tick ? '0 : div + DIV_W'(1);
      hcount        <= h_nxt;
      vcount        <= v_nxt;
      hsync_q       <= hsync_nxt;
      vsync_q       <= vsync_nxt;
      bright_q      <= bright_nxt;
      pix_tick_q    <= tick;
      line_start_q  <= tick && h_wrap;
      frame_start_q <= frame_wrap;
      if (frame_wrap) color_sel_q <= sw_sample;
    end
  end

  assign bus.pix_tick    = pix_tick_q;
  assign bus.hcount      = hcount;
  assign bus.vcount      = vcount;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.bright      = bright_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.color_sel   = color_sel_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: a reduced 20x12 raster for frame-level behaviour
// plus a default-parameter instance for the full 800-tick line.
module tb_vga_scan_ctrl;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  vga_scan_ctrl_if s_if ();
  vga_scan_ctrl_if d_if ();

  vga_scan_ctrl #(
    .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(17),
    .V_TOTAL(12), .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(10)
  ) u_small (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (s_if.master)
  );

  vga_scan_ctrl u_def (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (d_if.master)
  );

  typedef struct {
    int         adv;
    logic [2:0] sw;
    logic       pt;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       ls;
    logic       fs;
    logic [2:0] cs;
  } vec_t;

  vec_t vecs [14];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the small raster has just ticked onto (h,v); an expired budget is a failure.
  task automatic wait_at(input string name, input int h, input int v);
    int   cnt;
    logic found;
    cnt   = 0;
    found = 1'b0;
    while (!found && cnt < 2000) begin
      step();
      cnt++;
      found = s_if.pix_tick && (int'(s_if.hcount) == h) && (int'(s_if.vcount) == v);
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic wait_fs(output int cnt, output int ls_cnt);
    cnt    = 0;
    ls_cnt = 0;
    do begin
      step();
      cnt++;
      if (s_if.line_start) ls_cnt++;
    end while (!s_if.frame_start && cnt < 2000);
    if (!s_if.frame_start) check("frame_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hcount"}, 32'(s_if.hcount), 32'd0);
    check({tag, "_vcount"}, 32'(s_if.vcount), 32'd0);
    check({tag, "_hsync"},  32'(s_if.hsync),  32'd0);
    check({tag, "_vsync"},  32'(s_if.vsync),  32'd0);
    check({tag, "_bright"}, 32'(s_if.bright), 32'd0);
    check({tag, "_tick"},   32'(s_if.pix_tick), 32'd0);
    check({tag, "_ls"},     32'(s_if.line_start), 32'd0);
    check({tag, "_fs"},     32'(s_if.frame_start), 32'd0);
  endtask

  initial begin
    int         cnt, ls_cnt;
    int         tick_cnt, bright_cnt, hs_low, hs_err, d_ls;
    logic [2:0] exp_cs;

    // Cumulative clks from run going high: k; ticks m = k/2; h = m%20, v = (m/20)%12.
    vecs[0]  = '{1,   3'd0, 1'b0, 10'd0,  10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1,   3'd0, 1'b1, 10'd1,  10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1,   3'd0, 1'b0, 10'd1,  10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[3]  = '{5,   3'd0, 1'b1, 10'd4,  10'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[4]  = '{32,  3'd0, 1'b1, 10'd0,  10'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[5]  = '{1,   3'd0, 1'b0, 10'd0,  10'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[6]  = '{49,  3'd0, 1'b1, 10'd5,  10'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[7]  = '{40,  3'd0, 1'b1, 10'd5,  10'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[8]  = '{22,  3'd5, 1'b1, 10'd16, 10'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[9]  = '{2,   3'd5, 1'b1, 10'd17, 10'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{254, 3'd5, 1'b1, 10'd4,  10'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[11] = '{70,  3'd5, 1'b1, 10'd19, 10'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[12] = '{2,   3'd5, 1'b1, 10'd0,  10'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5};
    vecs[13] = '{1,   3'd5, 1'b0, 10'd0,  10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5};

    clr_n        = 1'b0;
    s_if.run     = 1'b0;
    s_if.switches = 3'd0;
    d_if.run     = 1'b0;
    d_if.switches = 3'd0;
    repeat (3) step();
    check_idle("reset");
    check("reset_csel", 32'(s_if.color_sel), 32'd0);
    clr_n = 1'b1;
    step();
    check_idle("idle_run0");

    s_if.run = 1'b1;
    for (int i = 0; i < 14; i++) begin
      s_if.switches = vecs[i].sw;
      repeat (vecs[i].adv) step();
      check($sformatf("v%0d_tick", i),   32'(s_if.pix_tick),    32'(vecs[i].pt));
      check($sformatf("v%0d_hcount", i), 32'(s_if.hcount),      32'(vecs[i].h));
      check($sformatf("v%0d_vcount", i), 32'(s_if.vcount),      32'(vecs[i].v));
      check($sformatf("v%0d_hsync", i),  32'(s_if.hsync),       32'(vecs[i].hs));
      check($sformatf("v%0d_vsync", i),  32'(s_if.vsync),       32'(vecs[i].vs));
      check($sformatf("v%0d_bright", i), 32'(s_if.bright),      32'(vecs[i].br));
      check($sformatf("v%0d_ls", i),     32'(s_if.line_start),  32'(vecs[i].ls));
      check($sformatf("v%0d_fs", i),     32'(s_if.frame_start), 32'(vecs[i].fs));
      check($sformatf("v%0d_csel", i),   32'(s_if.color_sel),   32'(vecs[i].cs));
    end

    // Switch toggling inside a frame: only the value present at the wrap counts.
    s_if.switches = 3'b110;
    repeat (50) step();
    check("toggle_hold_csel", 32'(s_if.color_sel), 32'd5);
    s_if.switches = 3'b001;
    wait_fs(cnt, ls_cnt);
    check("toggle_wait_clks", 32'(cnt), 32'd429);
    check("toggle_new_csel", 32'(s_if.color_sel), 32'd1);
    wait_fs(cnt, ls_cnt);
    check("frame_period_clks", 32'(cnt), 32'd480);
    check("frame_line_starts", 32'(ls_cnt), 32'd12);

    // Pause mid-frame, then restart from (0,0) without boundary pulses.
    wait_at("reach_10_5", 10, 5);
    s_if.run = 1'b0;
    step();
    check_idle("pause1");
    check("pause_csel", 32'(s_if.color_sel), 32'd1);
    repeat (4) step();
    check_idle("pause5");
    s_if.run = 1'b1;
    step();
    check_idle("restart1");
    step();
    check("restart2_tick",   32'(s_if.pix_tick),    32'd1);
    check("restart2_hcount", 32'(s_if.hcount),      32'd1);
    check("restart2_vcount", 32'(s_if.vcount),      32'd0);
    check("restart2_ls",     32'(s_if.line_start),  32'd0);
    check("restart2_fs",     32'(s_if.frame_start), 32'd0);
    check("restart_csel",    32'(s_if.color_sel),   32'd1);

    // Switch change one clk before the wrap edge.
    wait_at("reach_19_11", 19, 11);
    step();
    s_if.switches = 3'b010;
    step();
    check("late_fs", 32'(s_if.frame_start), 32'd1);
`ifdef VGA_SCAN_SWITCH_SYNC_EN
    exp_cs = 3'b001;
`else
    exp_cs = 3'b010;
`endif
    check("late_csel", 32'(s_if.color_sel), 32'(exp_cs));

    // Switch change three clks before the wrap edge is captured in either build.
    wait_at("reach_18_11", 18, 11);
    step();
    s_if.switches = 3'b100;
    repeat (3) step();
    check("early_fs",   32'(s_if.frame_start), 32'd1);
    check("early_csel", 32'(s_if.color_sel),   32'd4);

    // Full-size raster: first 800-tick line.
    check("def_idle_hsync", 32'(d_if.hsync), 32'd0);
    d_if.run   = 1'b1;
    tick_cnt   = 0;
    bright_cnt = 0;
    hs_low     = 0;
    hs_err     = 0;
    d_ls       = 0;
    for (int i = 0; i < 1600; i++) begin
      step();
      if (d_if.pix_tick) tick_cnt++;
      if (d_if.bright) bright_cnt++;
      if (d_if.line_start) d_ls++;
      if (d_if.pix_tick && !d_if.hsync) hs_low++;
      if (d_if.hsync !== (d_if.hcount >= 10'd96)) hs_err++;
    end
    check("def_hcount",     32'(d_if.hcount), 32'd0);
    check("def_vcount",     32'(d_if.vcount), 32'd1);
    check("def_ticks",      32'(tick_cnt),    32'd800);
    check("def_line_start", 32'(d_ls),        32'd1);
    check("def_bright",     32'(bright_cnt),  32'd0);
    check("def_hsync_low",  32'(hs_low),      32'd96);
    check("def_hsync_skew", 32'(hs_err),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
